// File: rtl/des_pkg.sv
// DES constant tables (bit positions in DES 1-based MSB-first numbering), decrypt shift schedule,
// FSM state type and the pure-wiring permutation helpers shared by the decrypt core.
package des_pkg;

  localparam int unsigned BLK_W  = 64;
  localparam int unsigned HALF_W = 32;
  localparam int unsigned CD_W   = 28;
  localparam int unsigned SK_W   = 48;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
    26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Right-rotate amount before each decrypt round; round 0 uses C0/D0 unrotated (K16).
  localparam int unsigned RSH_T [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Row-major S-box contents, indexed by {row, column} = {b5, b0, b4..b1}.
  localparam int unsigned SBOX_T [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7, 0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0, 15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10, 3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15, 13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7, 1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15, 13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4, 3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9, 14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14, 11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11, 10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6, 4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1, 13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2, 6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7, 1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8, 2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - IP_T[k])];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - FP_T[k])];
    return y;
  endfunction

  function automatic logic [47:0] e_perm(input logic [31:0] x);
    logic [47:0] y;
    for (int k = 0; k < 48; k++) y[6'(47 - k)] = x[5'(32 - E_T[k])];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    for (int k = 0; k < 32; k++) y[5'(31 - k)] = x[5'(32 - P_T[k])];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    for (int k = 0; k < 56; k++) y[6'(55 - k)] = x[6'(64 - PC1_T[k])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    for (int k = 0; k < 48; k++) y[6'(47 - k)] = x[6'(56 - PC2_T[k])];
    return y;
  endfunction

  function automatic logic key_parity_ok(input logic [63:0] k);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) ok = ok & (^k[6'(b * 8) +: 8]);
    return ok;
  endfunction

endpackage

// File: rtl/S1Box.sv
// DES substitution box S1: 6-bit input, 4-bit output.
module S1Box
  import des_pkg::*;
(
  input  logic [5:0] din,
  output logic [3:0] dout
);
  assign dout = 4'(SBOX_T[0][{din[5], din[0], din[4:1]}]);
endmodule

// File: rtl/S2Box.sv
// DES substitution box S2: 6-bit input, 4-bit output.
module S2Box
  import des_pkg::*;
(
  input  logic [5:0] din,
  output logic [3:0] dout
);
  assign dout = 4'(SBOX_T[1][{din[5], din[0], din[4:1]}]);
endmodule

// File: rtl/S3Box.sv
// DES substitution box S3: 6-bit input, 4-bit output.
module S3Box
  import des_pkg::*;
(
  input  logic [5:0] din,
  output logic [3:0] dout
);
  assign dout = 4'(SBOX_T[2][{din[5], din[0], din[4:1]}]);
endmodule

// File: rtl/S4Box.sv
// DES substitution box S4: 6-bit input, 4-bit output.
module S4Box
  import des_pkg::*;
(
  input  logic [5:0] din,
  output logic [3:0] dout
);
  assign dout = 4'(SBOX_T[3][{din[5], din[0], din[4:1]}]);
endmodule

// File: rtl/S5Box.sv
// DES substitution box S5: 6-bit input, 4-bit output.
module S5Box
  import des_pkg::*;
(
  input  logic [5:0] din,
  output logic [3:0] dout
);
  assign dout = 4'(SBOX_T[4][{din[5], din[0], din[4:1]}]);
endmodule

// File: rtl/S6Box.sv
// DES substitution box S6: 6-bit input, 4-bit output.
module S6Box
  import des_pkg::*;
(
  input  logic [5:0] din,
  output logic [3:0] dout
);
  assign dout = 4'(SBOX_T[5][{din[5], din[0], din[4:1]}]);
endmodule

// File: rtl/S7Box.sv
// DES substitution box S7: 6-bit input, 4-bit output.
module S7Box
  import des_pkg::*;
(
  input  logic [5:0] din,
  output logic [3:0] dout
);
  assign dout = 4'(SBOX_T[6][{din[5], din[0], din[4:1]}]);
endmodule

// File: rtl/S8Box.sv
// DES substitution box S8: 6-bit input, 4-bit output.
module S8Box
  import des_pkg::*;
(
  input  logic [5:0] din,
  output logic [3:0] dout
);
  assign dout = 4'(SBOX_T[7][{din[5], din[0], din[4:1]}]);
endmodule

// File: rtl/des_feistel_f.sv
// Combinational DES round function f(R, K): expand, key mix, S-box substitution, P permutation.
module des_feistel_f
  import des_pkg::*;
(
  input  logic [HALF_W-1:0] r,
  input  logic [SK_W-1:0]   subkey,
  output logic [HALF_W-1:0] f_c
);
  logic [SK_W-1:0]   x;
  logic [HALF_W-1:0] s;

  assign x = e_perm(r) ^ subkey;

  S1Box u_s1 (.din(x[47:42]), .dout(s[31:28]));
  S2Box u_s2 (.din(x[41:36]), .dout(s[27:24]));
  S3Box u_s3 (.din(x[35:30]), .dout(s[23:20]));
  S4Box u_s4 (.din(x[29:24]), .dout(s[19:16]));
  S5Box u_s5 (.din(x[23:18]), .dout(s[15:12]));
  S6Box u_s6 (.din(x[17:12]), .dout(s[11:8]));
  S7Box u_s7 (.din(x[11:6]),  .dout(s[7:4]));
  S8Box u_s8 (.din(x[5:0]),   .dout(s[3:0]));

  assign f_c = p_perm(s);
endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption, one Feistel round per clock, valid/ready in and out.
// Define DES_KEY_PARITY_CHECK_EN to reject keys with any even-parity byte (out_err=1, out_data=0).
module des_decrypt_core
  import des_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic [BLK_W-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             out_err
);
  state_e             state_q, state_d;
  logic [HALF_W-1:0]  l_q, l_d, r_q, r_d, f_c;
  logic [CD_W-1:0]    kc_q, kc_d, kd_q, kd_d, kc_rot, kd_rot;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SK_W-1:0]    subkey;
`ifdef DES_KEY_PARITY_CHECK_EN
  logic               err_q, err_d;
`endif

  // Reverse key schedule: rotate right, then select the round subkey.
  always_comb begin
    kc_rot = kc_q;
    kd_rot = kd_q;
    case (RSH_T[cnt_q])
      0:       ;
      1:       begin kc_rot = {kc_q[0], kc_q[27:1]};   kd_rot = {kd_q[0], kd_q[27:1]};   end
      default: begin kc_rot = {kc_q[1:0], kc_q[27:2]}; kd_rot = {kd_q[1:0], kd_q[27:2]}; end
    endcase
    subkey = pc2_perm({kc_rot, kd_rot});
  end

  des_feistel_f u_f (.r(r_q), .subkey(subkey), .f_c(f_c));

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    kc_d    = kc_q;
    kd_d    = kd_q;
    cnt_d   = cnt_q;
`ifdef DES_KEY_PARITY_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          {l_d, r_d}   = ip_perm(in_data);
          {kc_d, kd_d} = pc1_perm(in_key);
          cnt_d        = '0;
          state_d      = ROUND;
`ifdef DES_KEY_PARITY_CHECK_EN
          err_d        = 1'b0;
          // A bad key skips the rounds; zeroed L/R make the output word zero.
          if (!key_parity_ok(in_key)) begin
            l_d     = '0;
            r_d     = '0;
            kc_d    = '0;
            kd_d    = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      ROUND: begin
        kc_d  = kc_rot;
        kd_d  = kd_rot;
        l_d   = r_q;
        r_d   = l_q ^ f_c;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef DES_KEY_PARITY_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      kc_q    <= '0;
      kd_q    <= '0;
      cnt_q   <= '0;
`ifdef DES_KEY_PARITY_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      kc_q    <= kc_d;
      kd_q    <= kd_d;
      cnt_q   <= cnt_d;
`ifdef DES_KEY_PARITY_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Outputs decode flops only; final swap undone by feeding R||L to FP.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? fp_perm({r_q, l_q}) : '0;
`ifdef DES_KEY_PARITY_CHECK_EN
  assign out_err   = err_q;
`else
  assign out_err   = 1'b0;
`endif
endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed bench for des_decrypt_core using known DES vectors.
module tb_des_decrypt_core;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [63:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_err;

  int checks = 0;
  int errors = 0;
  int cnt;
  bit ir_high;
  bit unstable;

  localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] C1  = 64'h85E813540F0AB405;
  localparam logic [63:0] P1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] C2  = 64'h0000000000000000;
  localparam logic [63:0] P2  = 64'h8787878787878787;
  localparam logic [63:0] KBP = 64'h133457799BBCDFF0;

  des_decrypt_core dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [63:0] k);
    in_valid = 1'b1;
    in_data  = d;
    in_key   = k;
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("in_ready_after_accept", 64'(in_ready), 64'd0);
  endtask

  task automatic wait_out(input bit scramble, output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      if (scramble) begin
        in_data = {$urandom, $urandom};
        in_key  = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Textbook vector, consumer ready
    out_ready = 1'b1;
    send(C1, K1);
    wait_out(1'b0, cnt);
    chk("v1_latency", 64'(cnt), 64'd16);
    chk("v1_data", out_data, P1);
    chk("v1_err", 64'(out_err), 64'd0);
    @(posedge clk); #1;
    chk("v1_out_valid_drop", 64'(out_valid), 64'd0);
    chk("v1_in_ready_back", 64'(in_ready), 64'd1);

    // Zero ciphertext, inputs scrambled during rounds
    send(C2, K2);
    wait_out(1'b1, cnt);
    chk("v2_latency", 64'(cnt), 64'd16);
    chk("v2_data", out_data, P2);
    @(posedge clk); #1;

    // Back-to-back with in_valid held and backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = C1; in_key = K1;
    @(posedge clk); #1;
    in_data = C2; in_key = K2;
    ir_high = 1'b0;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 40) begin
      ir_high |= (in_ready !== 1'b0);
      @(posedge clk); #1;
      cnt++;
    end
    chk("b2b_latency", 64'(cnt), 64'd16);
    chk("b2b_data1", out_data, P1);
    unstable = 1'b0;
    repeat (5) begin
      ir_high |= (in_ready !== 1'b0);
      @(posedge clk); #1;
      unstable |= (out_data !== P1) || (out_valid !== 1'b1);
    end
    chk("b2b_in_ready_low", 64'(ir_high), 64'd0);
    chk("b2b_hold_stable", 64'(unstable), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("b2b_handshake_valid", 64'(out_valid), 64'd0);
    chk("b2b_handshake_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_second_accept", 64'(in_ready), 64'd0);
    wait_out(1'b0, cnt);
    chk("b2b_latency2", 64'(cnt), 64'd16);
    chk("b2b_data2", out_data, P2);
    @(posedge clk); #1;

    // Reset in the middle of the rounds
    send(C1, K1);
    repeat (8) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    chk("midrst_out_err", 64'(out_err), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("midrst_in_ready", 64'(in_ready), 64'd1);
    send(C2, K2);
    wait_out(1'b0, cnt);
    chk("midrst_latency", 64'(cnt), 64'd16);
    chk("midrst_data", out_data, P2);
    @(posedge clk); #1;

    // Key with an even-parity byte
    send(C1, KBP);
    wait_out(1'b0, cnt);
`ifdef DES_KEY_PARITY_CHECK_EN
    chk("parity_latency", 64'(cnt), 64'd1);
    chk("parity_err", 64'(out_err), 64'd1);
    chk("parity_data", out_data, 64'd0);
`else
    chk("parity_latency", 64'(cnt), 64'd16);
    chk("parity_err", 64'(out_err), 64'd0);
    chk("parity_data", out_data, P1);
`endif
    @(posedge clk); #1;
    chk("parity_in_ready", 64'(in_ready), 64'd1);
    chk("parity_out_valid", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/des_decrypt_core.md
# des_decrypt_core

Iterative DES decryption engine: accepts one 64-bit ciphertext block and 64-bit key, runs 16 Feistel rounds at one round per clock with the key schedule applied in reverse, and returns the 64-bit plaintext. It is the inverse-direction counterpart of the DES encryption datapath. It reuses the existing S1Box..S8Box substitution modules inside its round function, and sits behind a valid/ready stream interface.

## Interface
- No parameters; block size 64, key 64 (56 effective), 16 rounds are fixed by DES.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ciphertext/key pair present
- in_ready  out  1  block can accept a pair (high only in IDLE)
- in_data  in  64  ciphertext, bit 63 = DES bit 1
- in_key  in  64  key incl. parity bits, bit 63 = DES bit 1
- out_valid  out  1  plaintext present
- out_ready  in  1  consumer accepts plaintext
- out_data  out  64  plaintext
- out_err  out  1  key parity error flag, qualified by out_valid

## Operation
- States: IDLE, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: L/R <= IP(in_data); C/D <= PC1(in_key); round counter <= 0; go to ROUND.
- ROUND, counter i=0..15: subkey = PC2(C',D'), where C',D' = C,D rotated right by rsh[i]; rsh = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Register C,D <= C',D'; L <= R; R <= L ^ f(R, subkey). i=0 thus uses K16, i=15 uses K1. After i=15 go to DONE.
- DONE: out_valid=1, out_data = FP(R||L) (final swap undone), held stable until out_ready; on out_valid&&out_ready go to IDLE.
- f(): E-expansion 32->48, XOR subkey, eight 6->4 S-boxes (row = bits 5,0; column = bits 4:1), P permutation.
- All permutations are pure wiring; only L, R, C, D, counter (4 bits), state, out_err are flops.
- in_data/in_key need only be valid on the accept cycle; later changes are ignored.
- in_valid while not in IDLE: ignored (in_ready=0); no queuing.

## Timing
- Reset (async, any time, incl. mid-round or DONE): state IDLE, in_ready=1 after release, out_valid=0, out_data=0, out_err=0, L/R/C/D/counter=0. In-flight block is discarded.
- Accept on edge T; rounds on edges T+1..T+16; out_valid high from edge T+16. Latency 16 cycles.
- out_ready already high at T+16: handshake completes at edge T+17, in_ready high from T+17. Throughput one block per 18 cycles.
- out_ready low: out_valid, out_data, out_err hold indefinitely.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.

## Configuration
- DES_KEY_PARITY_CHECK_EN defined: on accept, each key byte checked for odd parity. Any even-parity byte -> skip ROUND, go to DONE on next edge with out_data=0, out_err=1; latency 1 cycle. Valid keys behave as above with out_err=0.
- Not defined: parity bits ignored, no check logic, out_err tied 0.

## Structure
- des_pkg: IP, FP, E, P, PC1, PC2 index tables; rsh decrypt shift schedule; state enum (IDLE, ROUND, DONE).
- Sub-module des_feistel_f: combinational f(R, subkey) instantiating S1Box..S8Box and P; top holds FSM, key schedule, registers.

## Test plan
- Key 133457799BBCDFF1, in_data 85E813540F0AB405, out_ready=1 -> out_data 0123456789ABCDEF, out_err=0, out_valid exactly 16 cycles after accept.
- Key 0E329232EA6D0D73, in_data 0000000000000000 -> out_data 8787878787878787.
- Back-to-back pairs with in_valid held high, out_ready held low 5 cycles after first result -> in_ready low throughout, out_data stable, second block accepted only after first handshake.
- rst_n pulsed low at round 8 -> out_valid=0, all outputs 0 immediately; new block after release decrypts correctly.
- in_data changed every cycle during ROUND -> result unaffected.
- With DES_KEY_PARITY_CHECK_EN, key 133457799BBCDFF0 -> out_valid one cycle after accept, out_err=1, out_data 0; without macro same key -> normal decrypt, out_err=0.
